// File: rtl/demux_route.sv
// rtl/demux_route.sv - registered 1-to-2 write-back demux with per-channel holding registers and transfer counters
module demux_route #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] demux_input,
  input  logic                  demux_in_valid,
  output logic                  demux_in_ready,
  input  logic                  demux_select,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [DATA_WIDTH-1:0] out2_data,
  output logic                  out2_valid,
  input  logic                  out2_ready,
  output logic [CNT_WIDTH-1:0]  xfer_count1,
  output logic [CNT_WIDTH-1:0]  xfer_count2
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic sel_ready;
  logic accept1;
  logic accept2;
  logic drain1;
  logic drain2;

  // Ready follows only the selected channel: free when empty or when it drains this cycle
  always_comb begin
    sel_ready = 1'b0;
    if (demux_select) begin
      sel_ready = !out2_valid | out2_ready;
    end else begin
      sel_ready = !out1_valid | out1_ready;
    end
  end

  assign demux_in_ready = sel_ready;

  // Input and output handshakes per channel; an unselected channel never sees an accept
  always_comb begin
    accept1 = demux_in_valid & sel_ready & !demux_select;
    accept2 = demux_in_valid & sel_ready &  demux_select;
    drain1  = out1_valid & out1_ready;
    drain2  = out2_valid & out2_ready;
  end

  // Channel 1 holding register: load on accept, clear valid on a drain without refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_data  <= '0;
      out1_valid <= 1'b0;
    end else if (accept1) begin
      out1_data  <= demux_input;
      out1_valid <= 1'b1;
    end else if (drain1) begin
      out1_valid <= 1'b0;
    end
  end

  // Channel 1 transfer counter: one step per output handshake, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count1 <= '0;
    end else if (drain1) begin
      xfer_count1 <= xfer_count1 + CNT_ONE;
    end
  end

  // Channel 2 holding register: load on accept, clear valid on a drain without refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out2_data  <= '0;
      out2_valid <= 1'b0;
    end else if (accept2) begin
      out2_data  <= demux_input;
      out2_valid <= 1'b1;
    end else if (drain2) begin
      out2_valid <= 1'b0;
    end
  end

  // Channel 2 transfer counter: one step per output handshake, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count2 <= '0;
    end else if (drain2) begin
      xfer_count2 <= xfer_count2 + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_demux_route.sv
// tb/tb_demux_route.sv - directed and randomized bench for demux_route against a queue-based reference model
module tb_demux_route;

  logic        clk;
  logic        rst_n;
  logic [15:0] demux_input;
  logic        demux_in_valid;
  logic        demux_in_ready;
  logic        demux_select;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [15:0] out2_data;
  logic        out2_valid;
  logic        out2_ready;
  logic [7:0]  xfer_count1;
  logic [7:0]  xfer_count2;

  int compared;
  int mismatched;

  // Reference model: each channel is a queue holding at most one word
  logic [15:0] m1[$];
  logic [15:0] m2[$];
  logic [15:0] last1;
  logic [15:0] last2;
  int          cnt1;
  int          cnt2;

  demux_route #(.DATA_WIDTH(16), .CNT_WIDTH(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .demux_input    (demux_input),
    .demux_in_valid (demux_in_valid),
    .demux_in_ready (demux_in_ready),
    .demux_select   (demux_select),
    .out1_data      (out1_data),
    .out1_valid     (out1_valid),
    .out1_ready     (out1_ready),
    .out2_data      (out2_data),
    .out2_valid     (out2_valid),
    .out2_ready     (out2_ready),
    .xfer_count1    (xfer_count1),
    .xfer_count2    (xfer_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m1.delete();
    m2.delete();
    last1 = 16'h0000;
    last2 = 16'h0000;
    cnt1  = 0;
    cnt2  = 0;
  endtask

  task automatic check_state(input string where);
    chk({where, " out1_valid"}, 32'(out1_valid), 32'(m1.size() != 0));
    chk({where, " out1_data"}, 32'(out1_data), 32'(last1));
    chk({where, " count1"}, 32'(xfer_count1), 32'(cnt1));
    chk({where, " out2_valid"}, 32'(out2_valid), 32'(m2.size() != 0));
    chk({where, " out2_data"}, 32'(out2_data), 32'(last2));
    chk({where, " count2"}, 32'(xfer_count2), 32'(cnt2));
  endtask

  // One clock cycle: drive, check ready, clock, advance model, check state
  task automatic step(input logic v, input logic s, input logic [15:0] d,
                      input logic r1, input logic r2, input string where);
    logic exp_rdy;
    logic acc;
    demux_input    = d;
    demux_in_valid = v;
    demux_select   = s;
    out1_ready     = r1;
    out2_ready     = r2;
    #1;
    if (s) exp_rdy = (m2.size() == 0) || r2;
    else   exp_rdy = (m1.size() == 0) || r1;
    chk({where, " in_ready"}, 32'(demux_in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    if (m1.size() != 0 && r1) begin
      void'(m1.pop_front());
      cnt1 = (cnt1 + 1) % 256;
    end
    if (m2.size() != 0 && r2) begin
      void'(m2.pop_front());
      cnt2 = (cnt2 + 1) % 256;
    end
    if (acc && !s) begin
      m1.push_back(d);
      last1 = d;
    end
    if (acc && s) begin
      m2.push_back(d);
      last2 = d;
    end
    #1;
    check_state(where);
  endtask

  initial begin
    int start2;
    compared       = 0;
    mismatched     = 0;
    rst_n          = 1'b0;
    demux_input    = 16'h0000;
    demux_in_valid = 1'b0;
    demux_select   = 1'b0;
    out1_ready     = 1'b0;
    out2_ready     = 1'b0;
    model_reset();

    // Reset state
    #1;
    check_state("reset");
    chk("reset in_ready", 32'(demux_in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle with valid low for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step(1'b0, i[0], 16'(32'hBEEF + i), 1'b1, 1'b1, "idle");
    end

    // Basic routing
    step(1'b1, 1'b0, 16'h1234, 1'b1, 1'b1, "basic1");
    chk("basic out1_data", 32'(out1_data), 32'h1234);
    step(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b1, "basic2");
    chk("basic out2_data", 32'(out2_data), 32'hABCD);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "basic3");
    chk("basic count1", 32'(xfer_count1), 32'd1);
    chk("basic count2", 32'(xfer_count2), 32'd1);

    // Back-pressure and head-of-line
    step(1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, "bp_load");
    step(1'b1, 1'b0, 16'h0002, 1'b0, 1'b0, "bp_stall");
    chk("bp held data", 32'(out1_data), 32'h0001);
    step(1'b1, 1'b1, 16'h0003, 1'b0, 1'b0, "bp_other");
    chk("bp other data", 32'(out2_data), 32'h0003);
    step(1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, "bp_release");
    chk("bp refill data", 32'(out1_data), 32'h0002);
    chk("bp refill valid", 32'(out1_valid), 32'd1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "bp_drain");

    // Streaming 20 words into channel 2
    start2 = cnt2;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 16'(32'h0100 + i), 1'b1, 1'b1, "stream");
    end
    step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, "stream_drain");
    chk("stream count2", 32'(xfer_count2), 32'((start2 + 20) % 256));

    // Reset mid-operation with channel 1 stalled on 0x5555
    step(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, "mid_load");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_state("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "post_reset");
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "post_reset2");

    // Counter wrap: 256 channel-1 transfers
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b0, 16'(i * 7), 1'b1, 1'b1, "wrap");
    end
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "wrap_drain");
    chk("wrap count1", 32'(xfer_count1), 32'd0);
    chk("wrap count2", 32'(xfer_count2), 32'd0);

    // Randomized traffic with independent back-pressure on both sinks
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
